// File: rtl/hazard_unit_if.sv
// ID-stage hazard query bus and hazard-unit response signals, shared by
// the pipeline (master) and the hazard unit (slave).
interface hazard_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) ();
    logic             en;
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] id_dst;
    logic             id_reg_write;
    logic             id_mem_to_reg;
    logic             ex_branch_taken;
    logic             stall;
    logic             flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output en, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dst, id_reg_write, id_mem_to_reg, ex_branch_taken,
        input  stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  en, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dst, id_reg_write, id_mem_to_reg, ex_branch_taken,
        output stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection and EXE forwarding control for a 5-stage MIPS pipeline,
// built on a two-entry (EXE/MEM) destination scoreboard.
module hazard_unit #(
    parameter int REG_W  = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          reset,
    hazard_unit_if.slave bus
);
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [REG_W-1:0] r_e_dst, r_m_dst;
    logic             r_e_we, r_e_ld, r_m_we;
    logic [1:0]       r_fwd_a, r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    logic       w_e_live, w_m_live;
    logic       w_ea, w_eb, w_ma, w_mb;
    logic       w_haz, w_stall, w_flush, w_bubble;
    logic [1:0] w_fa, w_fb;

    // $0 is hardwired, so a producer targeting it never creates a dependency
    assign w_e_live = r_e_we && (r_e_dst != '0);
    assign w_m_live = r_m_we && (r_m_dst != '0);

    assign w_ea = bus.id_valid && bus.id_use_rs && w_e_live && (r_e_dst == bus.id_rs);
    assign w_eb = bus.id_valid && bus.id_use_rt && w_e_live && (r_e_dst == bus.id_rt);
    assign w_ma = bus.id_valid && bus.id_use_rs && w_m_live && (r_m_dst == bus.id_rs);
    assign w_mb = bus.id_valid && bus.id_use_rt && w_m_live && (r_m_dst == bus.id_rt);

    always_comb begin
        w_haz = 1'b0;
        if (FWD_EN != 0) w_haz = (w_ea || w_eb) && r_e_ld;
        else             w_haz = w_ea || w_eb || w_ma || w_mb;
    end

    // a taken branch kills the consumer anyway, so it wins over any interlock
    assign w_flush  = bus.ex_branch_taken;
    assign w_stall  = w_haz && !w_flush && !reset;
    assign w_bubble = w_stall || w_flush || !bus.id_valid;

    always_comb begin
        w_fa = FWD_RF;
        w_fb = FWD_RF;
        if ((FWD_EN != 0) && !w_bubble) begin
            if (w_ea)      w_fa = FWD_MEM;
            else if (w_ma) w_fa = FWD_WB;
            if (w_eb)      w_fb = FWD_MEM;
            else if (w_mb) w_fb = FWD_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_e_dst     <= '0;
            r_e_we      <= 1'b0;
            r_e_ld      <= 1'b0;
            r_m_dst     <= '0;
            r_m_we      <= 1'b0;
            r_fwd_a     <= FWD_RF;
            r_fwd_b     <= FWD_RF;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (bus.en) begin
            r_m_dst <= r_e_dst;
            r_m_we  <= r_e_we;
            if (w_bubble) begin
                r_e_dst <= '0;
                r_e_we  <= 1'b0;
                r_e_ld  <= 1'b0;
            end else begin
                r_e_dst <= bus.id_dst;
                r_e_we  <= bus.id_reg_write;
                r_e_ld  <= bus.id_mem_to_reg;
            end
            r_fwd_a <= w_fa;
            r_fwd_b <= w_fb;
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.flush     = w_flush;
    assign bus.fwd_a     = r_fwd_a;
    assign bus.fwd_b     = r_fwd_b;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench: three hazard_unit builds (forwarding, stall-only, 2-bit
// counters) share one ID-stage stimulus; each vector checks one build.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_unit_if #(.REG_W(5), .CNT_W(16)) b0 ();
    hazard_unit_if #(.REG_W(5), .CNT_W(16)) b1 ();
    hazard_unit_if #(.REG_W(5), .CNT_W(2))  b2 ();

    hazard_unit #(.REG_W(5), .FWD_EN(1), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .bus(b0));
    hazard_unit #(.REG_W(5), .FWD_EN(0), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .bus(b1));
    hazard_unit #(.REG_W(5), .FWD_EN(1), .CNT_W(2))  u2 (.clk(clk), .reset(reset), .bus(b2));

    typedef struct {
        int       d;
        bit       rst;
        bit       v;
        bit [4:0] rs, rt;
        bit       urs, urt;
        bit [4:0] dst;
        bit       rw, ld, br;
        bit       st, fl;
        bit [1:0] fa, fb;
        bit       cc;
        int       sc, fc;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;
    vec_t tbl[$];

    function automatic vec_t mk(int d, bit rst, bit v, bit [4:0] rs, bit [4:0] rt,
                                bit urs, bit urt, bit [4:0] dst, bit rw, bit ld, bit br,
                                bit st, bit fl, bit [1:0] fa, bit [1:0] fb,
                                bit cc, int sc, int fc);
        vec_t r;
        r.d = d; r.rst = rst; r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
        r.dst = dst; r.rw = rw; r.ld = ld; r.br = br; r.st = st; r.fl = fl;
        r.fa = fa; r.fb = fb; r.cc = cc; r.sc = sc; r.fc = fc;
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit e, input bit v, input bit [4:0] rs, input bit [4:0] rt,
                         input bit urs, input bit urt, input bit [4:0] dst,
                         input bit rw, input bit ld, input bit br);
        b0.en = e; b0.id_valid = v; b0.id_rs = rs; b0.id_rt = rt; b0.id_use_rs = urs;
        b0.id_use_rt = urt; b0.id_dst = dst; b0.id_reg_write = rw; b0.id_mem_to_reg = ld;
        b0.ex_branch_taken = br;
        b1.en = e; b1.id_valid = v; b1.id_rs = rs; b1.id_rt = rt; b1.id_use_rs = urs;
        b1.id_use_rt = urt; b1.id_dst = dst; b1.id_reg_write = rw; b1.id_mem_to_reg = ld;
        b1.ex_branch_taken = br;
        b2.en = e; b2.id_valid = v; b2.id_rs = rs; b2.id_rt = rt; b2.id_use_rs = urs;
        b2.id_use_rt = urt; b2.id_dst = dst; b2.id_reg_write = rw; b2.id_mem_to_reg = ld;
        b2.ex_branch_taken = br;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int st, fl, fa, fb, sc, fc;
        string tag;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // addi $16,$0,5 ; addi $16,$16,-1 back to back -> EXE forward from MEM
        tbl.push_back(mk(0,1, 1, 0, 0,1,0,16,1,0,0, 0,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(0,0, 1,16, 0,1,0,16,1,0,0, 0,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(0,0, 0, 0, 0,0,0, 0,0,0,0, 0,0,2'b10,2'b00, 0,0,0));
        // same pair with a nop between -> forward from WB
        tbl.push_back(mk(0,1, 1, 0, 0,1,0,16,1,0,0, 0,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(0,0, 0, 0, 0,0,0, 0,0,0,0, 0,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(0,0, 1,16, 0,1,0,16,1,0,0, 0,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(0,0, 0, 0, 0,0,0, 0,0,0,0, 0,0,2'b01,2'b00, 0,0,0));
        // lw $8 ; add $9,$8,$8 -> one load-use stall then WB forward on both
        tbl.push_back(mk(0,1, 1, 0, 0,1,0, 8,1,1,0, 0,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(0,0, 1, 8, 8,1,1, 9,1,0,0, 1,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(0,0, 1, 8, 8,1,1, 9,1,0,0, 0,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(0,0, 0, 0, 0,0,0, 0,0,0,0, 0,0,2'b01,2'b01, 1,1,0));
        // stall-only build: addi $16 ; beq $16,$0 -> two interlock cycles
        tbl.push_back(mk(1,1, 1, 0, 0,1,0,16,1,0,0, 0,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(1,0, 1,16, 0,1,1, 0,0,0,0, 1,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(1,0, 1,16, 0,1,1, 0,0,0,0, 1,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(1,0, 1,16, 0,1,1, 0,0,0,0, 0,0,2'b00,2'b00, 1,2,0));
        tbl.push_back(mk(1,0, 0, 0, 0,0,0, 0,0,0,0, 0,0,2'b00,2'b00, 0,0,0));
        // addi $0,$0,7 then a reader of $0 -> nothing
        tbl.push_back(mk(0,1, 1, 0, 0,1,0, 0,1,0,0, 0,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(0,0, 1, 0, 0,1,1, 5,1,0,0, 0,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(0,0, 0, 0, 0,0,0, 0,0,0,0, 0,0,2'b00,2'b00, 0,0,0));
        // taken branch coinciding with load-use -> flush wins, E bubbled
        tbl.push_back(mk(0,1, 1, 0, 0,1,0, 8,1,1,0, 0,0,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(0,0, 1, 8, 8,1,1, 9,1,0,1, 0,1,2'b00,2'b00, 0,0,0));
        tbl.push_back(mk(0,0, 1, 8, 8,1,1, 9,1,0,0, 0,0,2'b00,2'b00, 1,0,1));
        tbl.push_back(mk(0,0, 0, 0, 0,0,0, 0,0,0,0, 0,0,2'b01,2'b01, 0,0,0));

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            drive(1, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt,
                  tbl[i].dst, tbl[i].rw, tbl[i].ld, tbl[i].br);
            #1;
            case (tbl[i].d)
                1: begin st = b1.stall; fl = b1.flush; fa = b1.fwd_a; fb = b1.fwd_b;
                         sc = b1.stall_cnt; fc = b1.flush_cnt; end
                default: begin st = b0.stall; fl = b0.flush; fa = b0.fwd_a; fb = b0.fwd_b;
                         sc = b0.stall_cnt; fc = b0.flush_cnt; end
            endcase
            tag = $sformatf("v%0d", i);
            chk({tag, ".stall"}, st, tbl[i].st);
            chk({tag, ".flush"}, fl, tbl[i].fl);
            chk({tag, ".fwd_a"}, fa, tbl[i].fa);
            chk({tag, ".fwd_b"}, fb, tbl[i].fb);
            if (tbl[i].cc) begin
                chk({tag, ".stall_cnt"}, sc, tbl[i].sc);
                chk({tag, ".flush_cnt"}, fc, tbl[i].fc);
            end
            cyc();
        end

        // reset asserted while a load-use stall is pending
        do_reset();
        drive(1, 1, 0, 0, 1, 0, 8, 1, 1, 0);
        cyc();
        drive(1, 1, 8, 8, 1, 1, 9, 1, 0, 0);
        reset = 1'b1;
        #1 chk("rst_mid.stall_held", b0.stall, 0);
        cyc();
        reset = 1'b0;
        #1 chk("rst_mid.stall_after", b0.stall, 0);
        cyc();

        // 2-bit counters: five load-use stalls saturate at 3
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, 1, 0, 0, 1, 0, 8, 1, 1, 0);
            cyc();
            drive(1, 1, 8, 8, 1, 1, 9, 1, 0, 0);
            #1 chk($sformatf("sat.stall%0d", k), b2.stall, 1);
            cyc();
            cyc();
        end
        #1 chk("sat.stall_cnt", b2.stall_cnt, 3);
        chk("sat.fwd_a", b2.fwd_a, 1);

        // en=0 with a branch pending: nothing registered may move
        drive(0, 1, 9, 9, 1, 1, 10, 1, 1, 1);
        #1 chk("frz.flush_comb", b2.flush, 1);
        cyc(); cyc(); cyc();
        #1 chk("frz.stall_cnt", b2.stall_cnt, 3);
        chk("frz.flush_cnt", b2.flush_cnt, 0);
        chk("frz.fwd_a", b2.fwd_a, 1);
        chk("frz.fwd_b", b2.fwd_b, 1);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1 chk("rst.stall", b2.stall, 0);
        chk("rst.flush", b2.flush, 0);
        chk("rst.fwd_a", b2.fwd_a, 0);
        chk("rst.fwd_b", b2.fwd_b, 0);
        chk("rst.stall_cnt", b2.stall_cnt, 0);
        chk("rst.flush_cnt", b2.flush_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
